val_matrix_seq: RTL and testbench

//  - Frame sequencer for the ValMatrix value-matrix resource: collects a ROWS x COLS matrix of

---
 rtl/val_matrix_seq.sv | 127 ++++++++++++
 tb/tb_val_matrix_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/val_matrix_seq.sv
// Frame sequencer: loads a ROWS x COLS matrix row-major from a stream, strobes it out in parallel,
// then drains it element by element. Define VAL_MATRIX_SEQ_TRANSPOSE_EN for column-major drain order.
module val_matrix_seq #(
  parameter  int ROWS  = 3,
  parameter  int COLS  = 7,
  parameter  int WIDTH = 4,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] mat [ROWS][COLS],
  output logic             mat_vld,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [RW-1:0]    o_row,
  output logic [CW-1:0]    o_col,
  output logic             o_last,
  output logic             busy
);

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_adv;
  logic          w_at_end;
  logic          w_col_major;

  assign w_in_hs  = i_valid && i_ready;
  assign w_out_hs = o_valid && o_ready;
  assign w_at_end = (r_row == RW'(ROWS - 1)) && (r_col == CW'(COLS - 1));
  assign w_adv    = (r_state == LOAD) ? w_in_hs : w_out_hs;

`ifdef VAL_MATRIX_SEQ_TRANSPOSE_EN
  assign w_col_major = (r_state == DRAIN);
`else
  assign w_col_major = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst || abort) r_state <= LOAD;
    else               r_state <= w_state_nxt;
  end

  // i_ready is held low while reset is asserted so nothing is accepted during reset
  always_comb begin
    w_state_nxt = r_state;
    i_ready     = 1'b0;
    o_valid     = 1'b0;
    case (r_state)
      LOAD: begin
        i_ready = rst;
        if (w_in_hs && w_at_end) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        o_valid = 1'b1;
        if (w_out_hs && w_at_end) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // one shared row/col counter serves as write pointer in LOAD and read pointer in DRAIN
  always_ff @(posedge clk) begin
    if (!rst || abort) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_adv) begin
      if (w_at_end) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_col_major) begin
        if (r_row == RW'(ROWS - 1)) begin
          r_row <= '0;
          r_col <= r_col + CW'(1);
        end else begin
          r_row <= r_row + RW'(1);
        end
      end else begin
        if (r_col == CW'(COLS - 1)) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  // abort leaves the buffer untouched; only reset clears it
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mat[r][c] <= '0;
    end else if (w_in_hs && !abort) begin
      mat[r_row][r_col] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || abort) begin
      mat_vld <= 1'b0;
      busy    <= 1'b0;
    end else begin
      mat_vld <= w_in_hs && w_at_end;
      if (w_in_hs)                   busy <= 1'b1;
      else if (w_out_hs && w_at_end) busy <= 1'b0;
    end
  end

  assign o_data = mat[r_row][r_col];
  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = (r_state == DRAIN) && w_at_end;

endmodule

// File: tb/tb_val_matrix_seq.sv
// Bench for val_matrix_seq (3x7x4): directed vectors with literal expectations plus a
// per-cycle comparison against a linear-index frame model.
module tb_val_matrix_seq;
  localparam int ROWS = 3, COLS = 7, WIDTH = 4, N = ROWS * COLS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, abort, i_valid, i_ready, mat_vld, o_valid, o_ready, o_last, busy;
  logic [WIDTH-1:0] i_data, o_data;
  logic [1:0]       o_row;
  logic [2:0]       o_col;
  logic [WIDTH-1:0] mat [ROWS][COLS];

  val_matrix_seq #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .abort(abort), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .mat(mat), .mat_vld(mat_vld), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_row(o_row), .o_col(o_col), .o_last(o_last), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

`ifdef VAL_MATRIX_SEQ_TRANSPOSE_EN
  int exp_ord [N] = '{0,7,14,1,8,15,2,9,0,3,10,1,4,11,2,5,12,3,6,13,4};
  int exp_r3  [3] = '{0,1,2};
  int exp_c3  [3] = '{0,0,0};
`else
  int exp_ord [N] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,0,1,2,3,4};
  int exp_r3  [3] = '{0,0,0};
  int exp_c3  [3] = '{0,1,2};
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: frame as a flat array, load count n and drain count k
  bit               m_loading = 1'b1;
  int               m_n = 0, m_k = 0;
  bit               m_vld = 1'b0, m_busy = 1'b0;
  logic [WIDTH-1:0] m_mat [N];

  function automatic int drain_idx(input int k);
`ifdef VAL_MATRIX_SEQ_TRANSPOSE_EN
    return (k % ROWS) * COLS + (k / ROWS);
`else
    return k;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_loading <= 1'b1; m_n <= 0; m_k <= 0; m_vld <= 1'b0; m_busy <= 1'b0;
      for (int i = 0; i < N; i++) m_mat[i] <= '0;
    end else if (abort) begin
      m_loading <= 1'b1; m_n <= 0; m_k <= 0; m_vld <= 1'b0; m_busy <= 1'b0;
    end else if (m_loading) begin
      m_vld <= 1'b0;
      if (i_valid) begin
        m_mat[m_n] <= i_data;
        m_busy     <= 1'b1;
        if (m_n == N - 1) begin
          m_loading <= 1'b0; m_n <= 0; m_vld <= 1'b1;
        end else m_n <= m_n + 1;
      end
    end else begin
      m_vld <= 1'b0;
      if (o_ready) begin
        if (m_k == N - 1) begin
          m_loading <= 1'b1; m_k <= 0; m_busy <= 1'b0;
        end else m_k <= m_k + 1;
      end
    end
  end

  int idx, bad;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("i_ready", i_ready, m_loading && rst);
      chk("o_valid", o_valid, !m_loading);
      chk("mat_vld", mat_vld, m_vld);
      chk("busy", busy, m_busy);
      if (!m_loading) begin
        idx = drain_idx(m_k);
        chk("o_data", o_data, m_mat[idx]);
        chk("o_row", o_row, idx / COLS);
        chk("o_col", o_col, idx % COLS);
        chk("o_last", o_last, m_k == N - 1);
      end
      bad = 0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (mat[r][c] !== m_mat[r * COLS + c]) bad++;
      chk("mat_diff_count", bad, 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int off);
    for (int k = 0; k < N; k++) begin
      i_valid = 1'b1;
      i_data  = WIDTH'((k + off) % 16);
      cyc();
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (o_valid === 1'b1 && t < 100) begin
      cyc();
      t++;
    end
    chk("drain_done", o_valid, 0);
  endtask

  int vld_cnt;
  initial begin
    rst = 1'b0; abort = 1'b0; i_valid = 1'b0; i_data = '0; o_ready = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b1;
    #1;
    chk("rst_i_ready", i_ready, 1);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_mat_vld", mat_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mat_2_6", mat[2][6], 0);

    // full load then unstalled drain
    load_frame(0);
    chk("ld_mat_vld", mat_vld, 1);
    chk("ld_mat_1_3", mat[1][3], 10);
    chk("ld_o_valid", o_valid, 1);
    cyc();
    chk("ld_mat_vld_pulse", mat_vld, 0);
    o_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("dr_data", o_data, exp_ord[i]);
      chk("dr_last", o_last, i == N - 1);
      if (i < 3) begin
        chk("dr_row", o_row, exp_r3[i]);
        chk("dr_col", o_col, exp_c3[i]);
      end
      cyc();
    end
    o_ready = 1'b0;
    chk("dr_end_o_valid", o_valid, 0);
    chk("dr_end_i_ready", i_ready, 1);
    chk("dr_end_busy", busy, 0);

    // backpressure at element 10
    load_frame(0);
    o_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    o_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", o_data, 10);
      chk("bp_row", o_row, 1);
      chk("bp_col", o_col, 3);
      chk("bp_valid", o_valid, 1);
      cyc();
    end
    o_ready = 1'b1;
    chk("bp_release_data", o_data, 10);
    cyc();
    chk("bp_next_data", o_data, exp_ord[11]);
    wait_idle();
    o_ready = 1'b0;

    // abort after 5 words, coincident element dropped
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_data = WIDTH'(k + 8);
      cyc();
    end
    abort = 1'b1; i_data = 4'hF;
    cyc();
    abort = 1'b0; i_valid = 1'b0;
    #1;
    chk("ab_busy", busy, 0);
    chk("ab_i_ready", i_ready, 1);
    chk("ab_mat_vld", mat_vld, 0);
    vld_cnt = 0;
    for (int k = 0; k < N; k++) begin
      i_valid = 1'b1; i_data = WIDTH'((k + 3) % 16);
      cyc();
      if (mat_vld === 1'b1) vld_cnt++;
    end
    i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (mat_vld === 1'b1) vld_cnt++;
    end
    chk("ab_vld_pulses", vld_cnt, 1);
    chk("ab_mat_0_0", mat[0][0], 3);
    chk("ab_mat_2_6", mat[2][6], 7);
    o_ready = 1'b1;
    wait_idle();

    // reset during drain element 7
    load_frame(0);
    for (int i = 0; i < 7; i++) cyc();
    chk("rd_data7", o_data, exp_ord[7]);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    chk("rd_o_valid", o_valid, 0);
    chk("rd_i_ready", i_ready, 1);
    chk("rd_mat_1_3", mat[1][3], 0);
    chk("rd_busy", busy, 0);

    // random valid/ready gaps checked by the per-cycle model
    vld_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data  = WIDTH'($urandom_range(0, 15));
      o_ready = 1'($urandom_range(0, 1));
      cyc();
      if (mat_vld === 1'b1) vld_cnt++;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    chk("rnd_frames_seen", vld_cnt > 1, 1);
    wait_idle();
    cyc();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
